i2c_bus_monitor: RTL and testbench

Parametrised passive I2C bus monitor: the next generation of the bus-level protocol checkers on the I2C core bench. It samples `scl_pad_i`/`sda_pad_i` on the Wishbone clock, synchronises and deglitches them, and decodes START, repeated START and STOP. It deserialises bytes and ACK bits, extracts the 7-bit address and R/W, and flags protocol errors with pulse outputs and a saturating error counter. It is instantiated beside the DUT in the testbench top and is synthesizable, so it can also serve as an on-chip bus sniffer.

---
 rtl/i2c_mon_pkg.sv | 18 +
 rtl/i2c_line_filter.sv | 47 ++++
 rtl/i2c_bus_monitor.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package  : i2c_mon_pkg
// Brief    : Shared types and constants for the I2C bus monitor.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_DATA = 2'd1,
        MON_ACK  = 2'd2
    } mon_state_t;

    localparam int I2C_BITS_PER_BYTE = 8;

endpackage : i2c_mon_pkg
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_filter
// Brief    : Two-flop synchroniser followed by a FILT_DEPTH-sample majority-free
//            deglitcher; output moves only when every history entry agrees.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
    parameter int FILT_DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic filt
);

    logic                  r_sync1;
    logic                  r_sync2;
    logic [FILT_DEPTH-1:0] r_hist;
    logic                  r_filt;

    // Reset level is 1 on every stage so an idle bus produces no edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= '1;
            r_filt  <= 1'b1;
        end else begin
            r_sync1   <= pad;
            r_sync2   <= r_sync1;
            r_hist[0] <= r_sync2;
            for (int i = 1; i < FILT_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
            if (&r_hist) begin
                r_filt <= 1'b1;
            end else if (~|r_hist) begin
                r_filt <= 1'b0;
            end
        end
    end

    assign filt = r_filt;

endmodule : i2c_line_filter
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_monitor
// Brief    : Passive I2C sniffer: decodes START/RSTART/STOP, bytes, address,
//            ACK, and flags protocol errors with a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int FILT_DEPTH = 3,
    parameter int TIMEOUT    = 1000,
    parameter int CNT_W      = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             scl_pad_i,
    input  logic             sda_pad_i,
    output logic             start_o,
    output logic             rstart_o,
    output logic             stop_o,
    output logic             busy_o,
    output logic             byte_valid_o,
    output logic [7:0]       byte_o,
    output logic             addr_valid_o,
    output logic [6:0]       addr_o,
    output logic             rw_o,
    output logic             ack_valid_o,
    output logic             ack_o,
    output logic             err_misplaced_o,
    output logic             err_timeout_o,
    output logic             err_sim_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int               TMO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);
    localparam logic [3:0]       c_last_bit = 4'(I2C_BITS_PER_BYTE - 1);

    // ------------------------------------------------------------------
    // Line conditioning and edge detection
    // ------------------------------------------------------------------
    logic w_scl_f;
    logic w_sda_f;
    logic r_scl_d;
    logic r_sda_d;

    i2c_line_filter #(.FILT_DEPTH(FILT_DEPTH)) u_scl_filt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .pad   (scl_pad_i),
        .filt  (w_scl_f)
    );

    i2c_line_filter #(.FILT_DEPTH(FILT_DEPTH)) u_sda_filt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .pad   (sda_pad_i),
        .filt  (w_sda_f)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl_f;
            r_sda_d <= w_sda_f;
        end
    end

    logic w_scl_rise;
    logic w_sim;
    logic w_start_cond;
    logic w_stop_cond;

    // Requiring SCL high on both samples excludes simultaneous changes.
    assign w_scl_rise   = w_scl_f & ~r_scl_d;
    assign w_sim        = (w_scl_f ^ r_scl_d) & (w_sda_f ^ r_sda_d);
    assign w_start_cond = r_sda_d & ~w_sda_f & r_scl_d & w_scl_f;
    assign w_stop_cond  = ~r_sda_d & w_sda_f & r_scl_d & w_scl_f;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    mon_state_t r_state, w_state_nxt;

    logic [6:0]       r_shift,      w_shift_nxt;
    logic [3:0]       r_bit_cnt,    w_bit_cnt_nxt;
    logic [3:0]       r_cnt_hi,     w_cnt_hi_nxt;
    logic             r_first,      w_first_nxt;
    logic [7:0]       r_byte,       w_byte_nxt;
    logic [6:0]       r_addr,       w_addr_nxt;
    logic             r_rw,         w_rw_nxt;
    logic             r_ack,        w_ack_nxt;
    logic             r_start,      w_start_nxt;
    logic             r_rstart,     w_rstart_nxt;
    logic             r_stop,       w_stop_nxt;
    logic             r_byte_valid, w_byte_valid_nxt;
    logic             r_addr_valid, w_addr_valid_nxt;
    logic             r_ack_valid,  w_ack_valid_nxt;
    logic             r_err_mis,    w_err_mis_nxt;
    logic             r_err_tmo,    w_err_tmo_nxt;
    logic             r_err_sim,    w_err_sim_nxt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [7:0] w_shift_in;
    logic       w_tmo_hit;
    logic       w_mid_byte;
    logic       w_any_err;

    assign w_shift_in = {r_shift, w_sda_f};
    assign w_tmo_hit  = (r_state != MON_IDLE) && !w_scl_f && (r_tmo_cnt == c_tmo_last);
    // START/STOP live inside an SCL-high phase whose rising edge is not a
    // real data bit, so judge placement by the count before that rise.
    assign w_mid_byte = (r_cnt_hi != 4'd0);
    assign w_any_err  = w_err_mis_nxt | w_err_tmo_nxt | w_err_sim_nxt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= MON_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_cnt_hi_nxt     = r_cnt_hi;
        w_first_nxt      = r_first;
        w_byte_nxt       = r_byte;
        w_addr_nxt       = r_addr;
        w_rw_nxt         = r_rw;
        w_ack_nxt        = r_ack;
        w_start_nxt      = 1'b0;
        w_rstart_nxt     = 1'b0;
        w_stop_nxt       = 1'b0;
        w_byte_valid_nxt = 1'b0;
        w_addr_valid_nxt = 1'b0;
        w_ack_valid_nxt  = 1'b0;
        w_err_mis_nxt    = 1'b0;
        w_err_tmo_nxt    = w_tmo_hit;
        w_err_sim_nxt    = w_sim;

        case (r_state)
            MON_IDLE: begin
                if (w_start_cond) begin
                    w_state_nxt   = MON_DATA;
                    w_bit_cnt_nxt = 4'd0;
                    w_cnt_hi_nxt  = 4'd0;
                    w_first_nxt   = 1'b1;
                    w_start_nxt   = 1'b1;
                end
            end
            MON_DATA, MON_ACK: begin
                if (w_tmo_hit) begin
                    w_state_nxt   = MON_IDLE;
                    w_bit_cnt_nxt = 4'd0;
                end else if (w_start_cond) begin
                    w_state_nxt   = MON_DATA;
                    w_rstart_nxt  = 1'b1;
                    w_err_mis_nxt = w_mid_byte;
                    w_bit_cnt_nxt = 4'd0;
                    w_cnt_hi_nxt  = 4'd0;
                    w_first_nxt   = 1'b1;
                end else if (w_stop_cond) begin
                    w_state_nxt   = MON_IDLE;
                    w_stop_nxt    = 1'b1;
                    w_err_mis_nxt = w_mid_byte;
                    w_bit_cnt_nxt = 4'd0;
                end else if (w_scl_rise) begin
                    w_cnt_hi_nxt = r_bit_cnt;
                    if (r_state == MON_DATA) begin
                        w_shift_nxt   = w_shift_in[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == c_last_bit) begin
                            w_state_nxt      = MON_ACK;
                            w_byte_valid_nxt = 1'b1;
                            w_byte_nxt       = w_shift_in;
                            if (r_first) begin
                                w_addr_valid_nxt = 1'b1;
                                w_addr_nxt       = w_shift_in[7:1];
                                w_rw_nxt         = w_shift_in[0];
                            end
                        end
                    end else begin
                        w_state_nxt     = MON_DATA;
                        w_ack_valid_nxt = 1'b1;
                        w_ack_nxt       = ~w_sda_f;
                        w_first_nxt     = 1'b0;
                        w_bit_cnt_nxt   = 4'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = MON_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_cnt_hi     <= '0;
            r_first      <= 1'b0;
            r_byte       <= '0;
            r_addr       <= '0;
            r_rw         <= 1'b0;
            r_ack        <= 1'b0;
            r_start      <= 1'b0;
            r_rstart     <= 1'b0;
            r_stop       <= 1'b0;
            r_byte_valid <= 1'b0;
            r_addr_valid <= 1'b0;
            r_ack_valid  <= 1'b0;
            r_err_mis    <= 1'b0;
            r_err_tmo    <= 1'b0;
            r_err_sim    <= 1'b0;
        end else begin
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_cnt_hi     <= w_cnt_hi_nxt;
            r_first      <= w_first_nxt;
            r_byte       <= w_byte_nxt;
            r_addr       <= w_addr_nxt;
            r_rw         <= w_rw_nxt;
            r_ack        <= w_ack_nxt;
            r_start      <= w_start_nxt;
            r_rstart     <= w_rstart_nxt;
            r_stop       <= w_stop_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_addr_valid <= w_addr_valid_nxt;
            r_ack_valid  <= w_ack_valid_nxt;
            r_err_mis    <= w_err_mis_nxt;
            r_err_tmo    <= w_err_tmo_nxt;
            r_err_sim    <= w_err_sim_nxt;
        end
    end

    // ------------------------------------------------------------------
    // SCL-low timeout and error counter
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == MON_IDLE) || w_scl_f || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_err_cnt <= '0;
        end else if (w_any_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign start_o         = r_start;
    assign rstart_o        = r_rstart;
    assign stop_o          = r_stop;
    assign busy_o          = (r_state != MON_IDLE);
    assign byte_valid_o    = r_byte_valid;
    assign byte_o          = r_byte;
    assign addr_valid_o    = r_addr_valid;
    assign addr_o          = r_addr;
    assign rw_o            = r_rw;
    assign ack_valid_o     = r_ack_valid;
    assign ack_o           = r_ack;
    assign err_misplaced_o = r_err_mis;
    assign err_timeout_o   = r_err_tmo;
    assign err_sim_o       = r_err_sim;
    assign err_cnt_o       = r_err_cnt;

endmodule : i2c_bus_monitor
`default_nettype wire

// File: tb/tb_i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_monitor
// Brief    : Self-checking bench; bit-stream reference model vs. event log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_monitor;

    localparam int FILT_DEPTH = 3;
    localparam int TIMEOUT    = 50;
    localparam int CNT_W      = 8;

    localparam logic [7:0] EV_S = 8'h53;
    localparam logic [7:0] EV_R = 8'h52;
    localparam logic [7:0] EV_P = 8'h50;
    localparam logic [7:0] EV_M = 8'h4d;
    localparam logic [7:0] EV_T = 8'h54;
    localparam logic [7:0] EV_X = 8'h58;
    localparam logic [7:0] EV_B = 8'h42;
    localparam logic [7:0] EV_A = 8'h41;
    localparam logic [7:0] EV_K = 8'h4b;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl   = 1'b1;
    logic sda   = 1'b1;

    logic             start_o, rstart_o, stop_o, busy_o;
    logic             byte_valid_o, addr_valid_o, rw_o, ack_valid_o, ack_o;
    logic [7:0]       byte_o;
    logic [6:0]       addr_o;
    logic             err_misplaced_o, err_timeout_o, err_sim_o;
    logic [CNT_W-1:0] err_cnt_o;

    always #5 clk = ~clk;

    i2c_bus_monitor #(
        .FILT_DEPTH (FILT_DEPTH),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .scl_pad_i       (scl),
        .sda_pad_i       (sda),
        .start_o         (start_o),
        .rstart_o        (rstart_o),
        .stop_o          (stop_o),
        .busy_o          (busy_o),
        .byte_valid_o    (byte_valid_o),
        .byte_o          (byte_o),
        .addr_valid_o    (addr_valid_o),
        .addr_o          (addr_o),
        .rw_o            (rw_o),
        .ack_valid_o     (ack_valid_o),
        .ack_o           (ack_o),
        .err_misplaced_o (err_misplaced_o),
        .err_timeout_o   (err_timeout_o),
        .err_sim_o       (err_sim_o),
        .err_cnt_o       (err_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [7:0] t, input logic [15:0] d);
        return {t, 8'h00, d};
    endfunction

    logic [31:0] act_q[$];
    logic [31:0] exp_q[$];

    // Observed event log, one entry per asserted pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_o)         act_q.push_back(ev(EV_S, 16'd0));
            if (rstart_o)        act_q.push_back(ev(EV_R, 16'd0));
            if (stop_o)          act_q.push_back(ev(EV_P, 16'd0));
            if (err_misplaced_o) act_q.push_back(ev(EV_M, 16'd0));
            if (err_timeout_o)   act_q.push_back(ev(EV_T, 16'd0));
            if (err_sim_o)       act_q.push_back(ev(EV_X, 16'd0));
            if (byte_valid_o)    act_q.push_back(ev(EV_B, {8'h00, byte_o}));
            if (addr_valid_o)    act_q.push_back(ev(EV_A, {8'h00, addr_o, rw_o}));
            if (ack_valid_o)     act_q.push_back(ev(EV_K, {15'd0, ack_o}));
        end
    end

    // Reference model: bus ownership, data bits of the current byte, and
    // the bit count seen before the SCL rise hosting a START/STOP.
    bit         m_busy  = 1'b0;
    bit         m_first = 1'b0;
    int         m_k     = 0;
    int         m_prev  = 0;
    int         m_errs  = 0;
    logic [7:0] m_cur   = 8'h00;
    int         H       = 6;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mdl_rise(input logic b);
        if (m_busy) begin
            m_prev = m_k;
            if (m_k < 8) begin
                m_cur = {m_cur[6:0], b};
                m_k++;
                if (m_k == 8) begin
                    exp_q.push_back(ev(EV_B, {8'h00, m_cur}));
                    if (m_first) exp_q.push_back(ev(EV_A, {8'h00, m_cur}));
                end
            end else begin
                exp_q.push_back(ev(EV_K, {15'd0, ~b}));
                m_k     = 0;
                m_first = 1'b0;
            end
        end
    endtask

    task automatic mdl_misplaced();
        if (m_prev >= 1 && m_prev <= 8) begin
            exp_q.push_back(ev(EV_M, 16'd0));
            m_errs++;
        end
    endtask

    task automatic drv_start();
        if (!scl) begin
            sda = 1'b1; tick(H);
            scl = 1'b1; mdl_rise(1'b1); tick(H);
        end
        sda = 1'b0;
        if (m_busy) begin
            exp_q.push_back(ev(EV_R, 16'd0));
            mdl_misplaced();
        end else begin
            exp_q.push_back(ev(EV_S, 16'd0));
        end
        m_busy = 1'b1; m_k = 0; m_prev = 0; m_first = 1'b1;
        tick(H);
        scl = 1'b0; tick(H);
    endtask

    task automatic drv_bit(input logic b);
        sda = b;    tick(H);
        scl = 1'b1; mdl_rise(b); tick(H);
        scl = 1'b0; tick(H);
    endtask

    task automatic drv_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) drv_bit(b[i]);
        drv_bit(~ack);
    endtask

    task automatic drv_stop();
        sda = 1'b0; tick(H);
        scl = 1'b1; mdl_rise(1'b0); tick(H);
        sda = 1'b1;
        if (m_busy) begin
            exp_q.push_back(ev(EV_P, 16'd0));
            mdl_misplaced();
            m_busy = 1'b0;
        end
        tick(H);
    endtask

    task automatic compare_events(input string tag);
        int n;
        tick(20);
        check_val({tag, "_nevents"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_val({tag, "_event"}, act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
        check_val({tag, "_errcnt"}, err_cnt_o, (m_errs > 255) ? 255 : m_errs);
        check_val({tag, "_busy"}, busy_o, m_busy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pulses"},
                  {start_o, rstart_o, stop_o, byte_valid_o, addr_valid_o,
                   ack_valid_o, err_misplaced_o, err_timeout_o, err_sim_o}, 9'd0);
        check_val({tag, "_busy"},   busy_o,    1'b0);
        check_val({tag, "_byte"},   byte_o,    8'h00);
        check_val({tag, "_addr"},   {addr_o, rw_o, ack_o}, 9'd0);
        check_val({tag, "_errcnt"}, err_cnt_o, 8'd0);
    endtask

    initial begin
        int         lat;
        int         nb;
        int         mode;
        int         nbits;
        bit         aborted;
        logic [7:0] ab;

        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(5);

        // Write to 0x50, data 0xA5, both ACKed.
        H = 6;
        drv_start();
        drv_byte(8'hA0, 1'b1);
        drv_byte(8'hA5, 1'b1);
        drv_stop();
        compare_events("write");
        check_val("write_addr", addr_o, 7'h50);
        check_val("write_rw",   rw_o,   1'b0);
        check_val("write_byte", byte_o, 8'hA5);
        check_val("write_ack",  ack_o,  1'b1);

        // STOP after four data bits.
        drv_start();
        drv_bit(1'b1); drv_bit(1'b0); drv_bit(1'b1); drv_bit(1'b1);
        drv_stop();
        compare_events("misplaced");
        check_val("misplaced_errcnt", err_cnt_o, 8'd1);

        // Read from 0x3C with a repeated START, NACK on the last byte.
        H = 7;
        drv_start();
        drv_byte(8'h79, 1'b1);
        drv_byte(8'h5E, 1'b1);
        drv_start();
        drv_byte(8'h79, 1'b1);
        drv_byte(8'hC3, 1'b0);
        drv_stop();
        compare_events("read");
        check_val("read_addr", addr_o, 7'h3C);
        check_val("read_rw",   rw_o,   1'b1);
        check_val("read_ack",  ack_o,  1'b0);

        // Two-cycle SDA glitch is filtered out.
        sda = 1'b0; tick(2);
        sda = 1'b1; tick(20);
        compare_events("glitch2");

        // Three-cycle glitch is a real START then STOP; latency counted in
        // negedges from the negedge that drove the pad low.
        lat = 0;
        sda = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) sda = 1'b1;
            if (start_o && lat == 0) lat = n;
        end
        check_val("start_latency", lat, FILT_DEPTH + 4);
        exp_q.push_back(ev(EV_S, 16'd0));
        exp_q.push_back(ev(EV_P, 16'd0));
        compare_events("glitch3");

        // SCL held low past the timeout.
        H = 6;
        drv_start();
        tick(TIMEOUT + 20);
        exp_q.push_back(ev(EV_T, 16'd0));
        m_errs++;
        m_busy = 1'b0;
        scl = 1'b1; tick(H);
        sda = 1'b1; tick(H);
        compare_events("timeout");

        // Both lines rise together on the first data bit.
        drv_start();
        drv_byte(8'hA0, 1'b1);
        if (sda) begin sda = 1'b0; tick(H); end
        scl = 1'b1; sda = 1'b1;
        exp_q.push_back(ev(EV_X, 16'd0));
        m_errs++;
        mdl_rise(1'b1);
        tick(H);
        scl = 1'b0; tick(H);
        for (int i = 6; i >= 0; i--) drv_bit(ab_const(i));
        drv_bit(1'b0);
        drv_stop();
        compare_events("simul");
        check_val("simul_byte", byte_o, 8'hAB);

        // Randomised transactions.
        for (int t = 0; t < 12; t++) begin
            H = $urandom_range(4, 10);
            aborted = 1'b0;
            drv_start();
            ab = 8'($urandom_range(0, 255));
            drv_byte(ab, $urandom_range(0, 3) != 0);
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb && !aborted; j++) begin
                mode = $urandom_range(0, 5);
                if (mode == 0) begin
                    nbits = $urandom_range(0, 8);
                    for (int b = 0; b < nbits; b++) drv_bit(1'($urandom_range(0, 1)));
                    drv_start();
                    drv_byte(8'($urandom_range(0, 255)), 1'b1);
                end else if (mode == 1) begin
                    nbits = $urandom_range(1, 7);
                    for (int b = 0; b < nbits; b++) drv_bit(1'($urandom_range(0, 1)));
                    aborted = 1'b1;
                end else begin
                    drv_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
                end
            end
            drv_stop();
            compare_events("random");
        end

        // Reset asserted in the middle of a byte.
        H = 5;
        drv_start();
        drv_bit(1'b0); drv_bit(1'b1); drv_bit(1'b1); drv_bit(1'b0);
        compare_events("pre_reset");
        rst_n = 1'b0;
        scl = 1'b1; sda = 1'b1;
        tick(2);
        check_reset_outputs("mid_reset");
        m_busy = 1'b0; m_k = 0; m_prev = 0; m_errs = 0; m_first = 1'b0;
        act_q.delete(); exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(5);
        drv_start();
        drv_byte(8'h2C, 1'b1);
        drv_stop();
        compare_events("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Low seven bits of 0xAB, MSB first, following the simultaneous-edge bit.
    function automatic logic ab_const(input int i);
        logic [6:0] v;
        v = 7'h2B;
        return v[i];
    endfunction

endmodule : tb_i2c_bus_monitor
`default_nettype wire
